// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the unified-memory port arbiter.
//             Holds the arbiter state encoding, the word size in bytes,
//             default parameter values and the beat-offset helper.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Two-state arbiter: the port is either free for the core or owned by a burst.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOAD = 1'b1
    } arb_state_t;

    localparam int WORD_BYTES         = 4;
    localparam int DEF_LEN_W          = 8;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Byte offset of word 'idx' from the burst base; wraps modulo 2^32.
    function automatic logic [31:0] word_offset(input logic [31:0] idx);
        return idx * 32'(WORD_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/burst_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : burst_addr_gen
//  Purpose  : Burst bookkeeping for the program loader. Latches the burst
//             base address and length, counts accepted beats and produces
//             the current write address and a last-beat flag.
//  Ports    : clk, rst    - clock, asynchronous active-high reset
//             i_load      - latch i_base/i_len and clear the beat counter
//             i_base      - burst start byte address
//             i_len       - beat count (0 encodes 2^LEN_W)
//             i_adv       - a beat was written this cycle
//             o_addr      - byte address of the current beat
//             o_last      - current beat is the final one of the burst
//  Revision : 1.0  initial release
// ============================================================================
module burst_addr_gen
    import mem_arb_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [31:0]      i_base,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_adv,
    output logic [31:0]      o_addr,
    output logic             o_last
);

    logic [31:0]      r_base;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_len_m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_base <= i_base;
            r_len  <= i_len;
            r_cnt  <= '0;
        end else if (i_adv) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // A length of 0 underflows to all-ones, so the last beat is index
    // 2^LEN_W-1: the zero encoding falls out of the modular subtraction.
    assign w_len_m1 = r_len - 1'b1;
    assign o_last   = (r_cnt == w_len_m1);
    assign o_addr   = r_base + word_offset(32'(r_cnt));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares the single port of the unified instruction/data memory
//             between the multi-cycle core (one word per grant) and a burst
//             program loader (consecutive-address write bursts). A fairness
//             flag alternates service when both requesters are active.
//  Ports    : clk, rst                      - clock, async active-high reset
//             core_req/we/addr/wdata        - core access request
//             core_gnt                      - core access performed this cycle
//             core_rvalid/core_rdata        - registered read response
//             ld_req/base/len               - loader burst request
//             ld_valid/ld_data/ld_ready     - loader beat handshake
//             ld_busy/ld_done/ld_err        - loader burst status
//             mem_addr/wdata/we, mem_rdata  - memory port
//  Config   : ARB_TIMEOUT_EN - abort a burst after TIMEOUT_CYCLES consecutive
//             cycles without a beat and pulse ld_err.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int LEN_W          = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_req,
    input  logic             core_we,
    input  logic [31:0]      core_addr,
    input  logic [31:0]      core_wdata,
    output logic             core_gnt,
    output logic             core_rvalid,
    output logic [31:0]      core_rdata,
    input  logic             ld_req,
    input  logic [31:0]      ld_base,
    input  logic [LEN_W-1:0] ld_len,
    input  logic             ld_valid,
    input  logic [31:0]      ld_data,
    output logic             ld_ready,
    output logic             ld_busy,
    output logic             ld_done,
    output logic             ld_err,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_we,
    input  logic [31:0]      mem_rdata
);

    arb_state_t  r_state;
    arb_state_t  w_next;
    logic        r_last_ld;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_err;

    logic        w_gnt;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_ld_win;
    logic        w_beat;
    logic        w_burst_end;
    logic        w_abort;
    logic        w_timeout;
    logic [31:0] w_burst_addr;
    logic        w_last;

    burst_addr_gen #(
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_ld_win),
        .i_base (ld_base),
        .i_len  (ld_len),
        .i_adv  (w_beat),
        .o_addr (w_burst_addr),
        .o_last (w_last)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_idle_cnt;

    // Counts consecutive beat-less cycles inside a burst; any beat, or
    // leaving the burst, restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if ((r_state != ARB_LOAD) || ld_valid) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
    assign w_timeout = (r_state == ARB_LOAD) && !ld_valid &&
                       (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;

    // The loader may stall indefinitely; TIMEOUT_CYCLES is kept only so both
    // builds present the same parameter list.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // Next-state and port muxing.
    always_comb begin
        w_next      = r_state;
        w_gnt       = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        w_ld_win    = 1'b0;
        w_beat      = 1'b0;
        w_burst_end = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // The loader yields to a waiting core only if it was served last.
                if (ld_req && (!core_req || !r_last_ld)) begin
                    w_ld_win = 1'b1;
                    w_next   = ARB_LOAD;
                end else if (core_req) begin
                    w_gnt   = 1'b1;
                    w_we    = core_we;
                    w_addr  = core_addr;
                    w_wdata = core_wdata;
                end
            end
            ARB_LOAD: begin
                if (ld_valid) begin
                    w_beat  = 1'b1;
                    w_we    = 1'b1;
                    w_addr  = w_burst_addr;
                    w_wdata = ld_data;
                    if (w_last) begin
                        w_burst_end = 1'b1;
                        w_next      = ARB_IDLE;
                    end
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = ARB_IDLE;
                end
            end
            default: begin
                w_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_last_ld <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_gnt) begin
                r_last_ld <= 1'b0;
            end else if (w_burst_end || w_abort) begin
                r_last_ld <= 1'b1;
            end
            r_rvalid <= w_gnt && !core_we;
            if (w_gnt && !core_we) begin
                r_rdata <= mem_rdata;
            end
            r_done <= w_burst_end;
            r_err  <= w_abort;
        end
    end

    // The combinational paths are masked by rst so nothing reaches the
    // memory or the core while reset is asserted.
    assign core_gnt    = w_gnt & ~rst;
    assign mem_we      = w_we & ~rst;
    assign mem_addr    = rst ? 32'h0 : w_addr;
    assign mem_wdata   = rst ? 32'h0 : w_wdata;
    assign core_rvalid = r_rvalid;
    assign core_rdata  = r_rdata;
    assign ld_busy     = (r_state == ARB_LOAD);
    assign ld_ready    = (r_state == ARB_LOAD);
    assign ld_done     = r_done;
    assign ld_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Stimulus pushes the
//             expected memory writes and read responses into queues; a
//             monitor on the falling edge pops and compares them whenever
//             the DUT writes memory or presents read data. Directed checks
//             cover reset, grant timing, fairness, wrap and length encoding.
//  Config   : ARB_TIMEOUT_EN - also exercises the loader timeout abort.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LEN_W = 8;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic             clk;
    logic             rst;
    logic             core_req;
    logic             core_we;
    logic [31:0]      core_addr;
    logic [31:0]      core_wdata;
    logic             core_gnt;
    logic             core_rvalid;
    logic [31:0]      core_rdata;
    logic             ld_req;
    logic [31:0]      ld_base;
    logic [LEN_W-1:0] ld_len;
    logic             ld_valid;
    logic [31:0]      ld_data;
    logic             ld_ready;
    logic             ld_busy;
    logic             ld_done;
    logic             ld_err;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    logic [31:0] mem [0:4095];
    wr_t         q_wr[$];
    logic [31:0] q_rd[$];
    int          n_cmp;
    int          n_bad;
    int          n_done;
    int          n_err;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES (64),
        .LEN_W          (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .ld_req      (ld_req),
        .ld_base     (ld_base),
        .ld_len      (ld_len),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_busy     (ld_busy),
        .ld_done     (ld_done),
        .ld_err      (ld_err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write at the rising edge.
    always_comb mem_rdata = mem[mem_addr[13:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[13:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : mon
        wr_t         e;
        logic [31:0] r;
        if (mem_we) begin
            if (q_wr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write actual=%h:%h expected=none", mem_addr, mem_wdata);
            end else begin
                e = q_wr.pop_front();
                chk("wr_addr", mem_addr, e.a);
                chk("wr_data", mem_wdata, e.d);
            end
        end
        if (core_rvalid) begin
            if (q_rd.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rvalid actual=%h expected=none", core_rdata);
            end else begin
                r = q_rd.pop_front();
                chk("rd_data", core_rdata, r);
            end
        end
        if (ld_done) n_done++;
        if (ld_err)  n_err++;
    end

    task automatic core_access(input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] exp_rd);
        wr_t e;
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = a;
        core_wdata = d;
        if (we) begin
            e.a = a;
            e.d = d;
            q_wr.push_back(e);
        end else begin
            q_rd.push_back(exp_rd);
        end
        @(negedge clk);
        chk("core_gnt_same_cycle", {31'b0, core_gnt}, 32'd1);
        @(posedge clk); #1;
        core_req = 1'b0;
        core_we  = 1'b0;
        if (!we) begin
            @(negedge clk);
            chk("core_rvalid_next", {31'b0, core_rvalid}, 32'd1);
        end
    endtask

    // Burst with ld_valid held high; beat i carries seed+i at base+4*i.
    task automatic run_burst(input logic [31:0] base, input logic [LEN_W-1:0] len,
                             input int n, input logic [31:0] seed, input logic core_pending);
        int  n0;
        wr_t e;
        n0 = n_done;
        for (int i = 0; i < n; i++) begin
            e.a = base + 32'(i * 4);
            e.d = seed + 32'(i);
            q_wr.push_back(e);
        end
        ld_req   = 1'b1;
        ld_base  = base;
        ld_len   = len;
        ld_valid = 1'b1;
        ld_data  = seed;
        @(negedge clk);
        chk("accept_gnt", {31'b0, core_gnt}, 32'd0);
        chk("accept_busy", {31'b0, ld_busy}, 32'd0);
        @(posedge clk); #1;
        ld_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            ld_data = seed + 32'(i);
            @(negedge clk);
            chk("beat_busy", {31'b0, ld_busy & ld_ready}, 32'd1);
            chk("beat_no_gnt", {31'b0, core_gnt}, 32'd0);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        @(negedge clk);
        chk("end_busy", {31'b0, ld_busy}, 32'd0);
        chk("ld_done", {31'b0, ld_done}, 32'd1);
        chk("post_burst_gnt", {31'b0, core_gnt}, {31'b0, core_pending});
        @(posedge clk); #1;
        chk("done_count", 32'(n_done - n0), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        n_bad++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int  n0;
        int  k;
        wr_t e;
        n_cmp = 0; n_bad = 0; n_done = 0; n_err = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

        // Reset with every request active: outputs must still be 0.
        rst        = 1'b1;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h0000_0040;
        core_wdata = 32'h1234_5678;
        ld_req     = 1'b1;
        ld_base    = 32'h0000_0200;
        ld_len     = 8'd2;
        ld_valid   = 1'b1;
        ld_data    = 32'h5A5A_0001;
        #3;
        chk("rst_core_gnt", {31'b0, core_gnt}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_status", {28'b0, ld_busy, ld_ready, ld_done, ld_err}, 32'h0);
        chk("rst_rvalid", {31'b0, core_rvalid}, 32'd0);
        chk("rst_rdata", core_rdata, 32'h0);

        // Fairness: both held high out of reset. last_ld=0, so the loader
        // takes the first IDLE, then one core write per 2-beat burst.
        core_addr  = 32'h0000_0300;
        core_wdata = 32'hC0DE_0000;
        for (int r = 0; r < 3; r++) begin
            e.a = 32'h200; e.d = 32'h5A5A_0001; q_wr.push_back(e);
            e.a = 32'h204; e.d = 32'h5A5A_0001; q_wr.push_back(e);
            e.a = 32'h300; e.d = 32'hC0DE_0000; q_wr.push_back(e);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("fair_gnt", {31'b0, core_gnt}, {31'b0, (c % 4) == 3});
            chk("fair_busy", {31'b0, ld_busy}, {31'b0, ((c % 4) == 1) || ((c % 4) == 2)});
            @(posedge clk); #1;
        end
        core_req = 1'b0; core_we = 1'b0; ld_req = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        chk("fair_done_count", 32'(n_done), 32'd3);
        @(posedge clk); #1;

        // Core write then read of the same word.
        core_access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0);
        core_access(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Burst of 4 with a core read waiting; the core is served right after.
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h0000_0040;
        q_rd.push_back(32'hDEAD_BEEF);
        run_burst(32'h0000_0100, 8'd4, 4, 32'h0000_0001, 1'b1);
        core_req = 1'b0;
        @(negedge clk);
        chk("burst_rvalid", {31'b0, core_rvalid}, 32'd1);
        chk("done_single", {31'b0, ld_done}, 32'd0);
        @(posedge clk); #1;

        // Address wrap: 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
        run_burst(32'hFFFF_FFF8, 8'd3, 3, 32'h0000_00B0, 1'b0);
        chk("wrap_word0", mem[0], 32'h0000_00B2);

        // Length 0 encodes 256 beats.
        run_burst(32'h0000_1000, 8'd0, 256, 32'h1000_0000, 1'b0);

        // Reset after two beats of an 8-beat burst.
        n0 = n_done;
        e.a = 32'h400; e.d = 32'hE0; q_wr.push_back(e);
        e.a = 32'h404; e.d = 32'hE1; q_wr.push_back(e);
        ld_req = 1'b1; ld_base = 32'h400; ld_len = 8'd8; ld_valid = 1'b1; ld_data = 32'hE0;
        @(posedge clk); #1;
        ld_req = 1'b0;
        @(posedge clk); #1;
        ld_data = 32'hE1;
        @(posedge clk); #1;
        ld_data = 32'hE2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {30'b0, ld_busy, ld_ready}, 32'h0);
        chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ld_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(n_done - n0), 32'd0);
        chk("midrst_word1", mem[32'h404 >> 2], 32'hE1);
        chk("midrst_word2", mem[32'h408 >> 2], 32'h0);

`ifdef ARB_TIMEOUT_EN
        // One beat, then ld_valid low: 64 idle cycles abort the burst and the
        // waiting core is granted in the same cycle ld_err pulses.
        n0 = n_done;
        e.a = 32'h600; e.d = 32'hF0; q_wr.push_back(e);
        ld_req = 1'b1; ld_base = 32'h600; ld_len = 8'd4; ld_valid = 1'b1; ld_data = 32'hF0;
        @(posedge clk); #1;
        ld_req = 1'b0;
        @(posedge clk); #1;
        ld_valid   = 1'b0;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h700;
        core_wdata = 32'h77;
        e.a = 32'h700; e.d = 32'h77; q_wr.push_back(e);
        k = 0;
        while (k < 200) begin
            k++;
            @(negedge clk);
            if (ld_err) break;
        end
        chk("to_cycles", 32'(k), 32'd65);
        chk("to_core_gnt", {31'b0, core_gnt}, 32'd1);
        chk("to_idle", {31'b0, ld_busy}, 32'd0);
        @(posedge clk); #1;
        core_req = 1'b0; core_we = 1'b0;
        @(negedge clk);
        chk("to_err_pulse", {31'b0, ld_err}, 32'd0);
        chk("to_err_count", 32'(n_err), 32'd1);
        chk("to_no_done", 32'(n_done - n0), 32'd0);
`else
        chk("no_err", 32'(n_err), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("wr_queue_empty", 32'(q_wr.size()), 32'd0);
        chk("rd_queue_empty", 32'(q_rd.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
